ieeedrv_track_ctl: RTL and testbench
====================================

# ieeedrv_track_ctl

Parametrised track-buffer controller for the 4040/8250 IEEE drive model. It keeps one track buffer per sub-drive. For each buffer it decides when the SD image must supply a track (mount, track step) or take one back (write-back of a modified buffer). Track geometry comes from an external lookup port, so new drive types need no RTL change. It sits between the per-sub-drive DOS/GCR logic and the shared SD block interface.

## Interface
Parameters:
- SUBDRV, 2: number of sub-drives / track buffers (1..4).
- TRK_W, 8: track number width; track 0 and all-ones are invalid ("none").
- LBA_W, 32: SD block address width.
- BLK_W, 6: block-count width (count is blocks-1).
- INIT_TRK0, 39: directory track loaded after mount for drv_type 0 (8250).
- INIT_TRK1, 18: directory track loaded after mount for drv_type 1 (4040).
- Derived: SW = max(1, clog2(SUBDRV)).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- drv_type  in  1  geometry/initial-track select.
- mounted  in  SUBDRV  image present per sub-drive, level.
- drv_sel  in  SW  sub-drive currently selected by the DOS; given service priority.
- track[SUBDRV]  in  TRK_W  requested track per sub-drive.
- wr_mark  in  SUBDRV  one-cycle pulse: buffer modified.
- flush  in  SUBDRV  one-cycle pulse: write the buffer back if dirty.
- geom_trk  out  TRK_W  track being looked up.
- geom_lba  in  LBA_W  first block of geom_trk, valid 1 cycle after geom_trk.
- geom_cnt  in  BLK_W  blocks-1 of geom_trk, same timing.
- sd_lba[SUBDRV]  out  LBA_W  reset 0.
- sd_blk_cnt[SUBDRV]  out  BLK_W  reset 0.
- sd_rd, sd_wr  out  SUBDRV  request strobes; reset 0.
- sd_ack  in  SUBDRV  SD transfer in progress.
- drv_act  out  SW  sub-drive owning the SD port; reset 0.
- ltrack[SUBDRV]  out  TRK_W  track held in each buffer; reset all-ones.
- dirty  out  SUBDRV  buffer modified since load/write; reset 0.
- busy  out  SUBDRV  transfer pending or active; reset 0.

## Operation
- Per sub-drive, the block keeps:
  - an init flag: set on a mounted rising edge and, for every mounted drive, on leaving reset;
  - a flush-pending flag: set by flush while dirty.
- wr_mark[n] sets dirty[n]. It is ignored while mounted[n]=0.
- Unmount (mounted falling edge) clears dirty, flush-pending and init for that sub-drive and sets ltrack to all-ones. A transfer already in flight completes, but its result is discarded: ltrack stays all-ones.
- FSM states: IDLE, LOOKUP, LATCH, REQ, XFER.
- IDLE scan: drv_sel is checked first, then the other sub-drives round-robin upward with wrap, starting from drv_act+1. The first sub-drive n with work is chosen, using this priority:
  1. flush-pending → write ltrack[n];
  2. init → if dirty, write ltrack[n] first; otherwise read the init track;
  3. track[n] valid and different from ltrack[n] → if dirty, write ltrack[n] first; otherwise read track[n].
  - Sub-drives that are unmounted, or whose target is invalid, are skipped.
- IDLE→LOOKUP: drv_act←n, busy[n]←1, geom_trk←target track.
- LOOKUP→LATCH: wait for the geometry data.
- LATCH→REQ: sd_lba[n]←geom_lba, sd_blk_cnt[n]←geom_cnt. For a write, dirty[n] and flush-pending[n] are cleared in this cycle.
- REQ: sd_rd[n] or sd_wr[n] is held high until sd_ack[n] is sampled high, then dropped. Go to XFER.
- XFER: on the sd_ack[n] falling edge:
  - after a read: ltrack[n]←target and the init flag is cleared;
  - then busy[n]←0 and return to IDLE.
- A dirty track change therefore costs two back-to-back transactions: write the old track, then read the new one.
- wr_mark arriving during or after the write's LATCH cycle leaves dirty=1. Set has priority over clear in the same cycle.
- track[n] changing while n is busy has no effect on the current transfer. The new value is evaluated at the next IDLE.
- reset_n low at any time forces every register to its reset value and the FSM to IDLE immediately. sd_rd/sd_wr drop asynchronously.

## Timing
- An IDLE decision at cycle T gives geom_trk at T+1, sd_lba/sd_blk_cnt at T+3, and sd_rd/sd_wr high from T+3.
- busy[n] is high from T+1 through the cycle after sd_ack[n] falls.
- Only one transaction is outstanding at a time. sd_* outputs for other sub-drives hold their last values.
- The minimum gap between the end of one transaction and the next IDLE decision is 1 cycle.

## Test plan
- Reset released with mounted=2'b01, drv_type=0 → geom_trk=39, sd_rd[0] high 3 cycles later. After an ack pulse: ltrack[0]=39, busy[0]=0, and sub-drive 1 sees no request.
- Sub-drive 0 clean at track 39, track[0]←40 → one read with sd_lba/sd_blk_cnt taken from the lookup for track 40 (e.g. 1131/26). Then ltrack[0]=40.
- wr_mark[0], then track[0]←41 → sd_wr[0] for track 40, then sd_rd[0] for track 41. dirty=0 after the write's LATCH cycle.
- wr_mark[0] pulsed during XFER of the write-back → dirty[0]=1 after completion. A later flush[0] issues a write of track 41.
- Both sub-drives need reads, drv_sel=1 → sub-drive 1 is serviced first, then sub-drive 0. drv_act follows the service order.
- mounted[1] falls during an XFER of sub-drive 1 → the transfer completes, ltrack[1]=all-ones, dirty[1]=0, and no further request is made for sub-drive 1.

Source files
------------

// File: rtl/ieeedrv_track_ctl.sv
// rtl/ieeedrv_track_ctl.sv - track-buffer controller for the 4040/8250 IEEE drive model
//
// One track buffer per sub-drive. Decides when the SD image must supply a
// track (mount, step) or take a modified one back, and runs one SD
// transaction at a time through the shared block interface.
//
// Ports:
//   clk_sys, reset_n        clock, asynchronous active-low reset
//   drv_type                0: 8250 geometry/initial track, 1: 4040
//   mounted[n]              image present (level)
//   drv_sel                 sub-drive selected by the DOS, scanned first
//   track[n]                requested track
//   wr_mark[n], flush[n]    buffer-modified / write-back pulses
//   geom_trk -> geom_lba/geom_cnt   external geometry lookup, 1-cycle latency
//   sd_lba[n], sd_blk_cnt[n], sd_rd[n], sd_wr[n], sd_ack[n]   SD block port
//   drv_act                 sub-drive owning the SD port
//   ltrack[n], dirty[n], busy[n]    buffer status

module ieeedrv_track_ctl #(
    parameter int SUBDRV    = 2,
    parameter int TRK_W     = 8,
    parameter int LBA_W     = 32,
    parameter int BLK_W     = 6,
    parameter int INIT_TRK0 = 39,
    parameter int INIT_TRK1 = 18,
    localparam int SW       = (SUBDRV > 1) ? $clog2(SUBDRV) : 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              drv_type,
    input  logic [SUBDRV-1:0] mounted,
    input  logic [SW-1:0]     drv_sel,
    input  logic [TRK_W-1:0]  track [SUBDRV],
    input  logic [SUBDRV-1:0] wr_mark,
    input  logic [SUBDRV-1:0] flush,
    output logic [TRK_W-1:0]  geom_trk,
    input  logic [LBA_W-1:0]  geom_lba,
    input  logic [BLK_W-1:0]  geom_cnt,
    output logic [LBA_W-1:0]  sd_lba [SUBDRV],
    output logic [BLK_W-1:0]  sd_blk_cnt [SUBDRV],
    output logic [SUBDRV-1:0] sd_rd,
    output logic [SUBDRV-1:0] sd_wr,
    input  logic [SUBDRV-1:0] sd_ack,
    output logic [SW-1:0]     drv_act,
    output logic [TRK_W-1:0]  ltrack [SUBDRV],
    output logic [SUBDRV-1:0] dirty,
    output logic [SUBDRV-1:0] busy
);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_LATCH, S_REQ, S_XFER} state_t;

    state_t            state;
    logic              is_wr;
    logic              discard;     // owner unmounted mid-transfer: drop the result
    logic [TRK_W-1:0]  tgt;
    logic [SUBDRV-1:0] mounted_q;
    logic [SUBDRV-1:0] init;
    logic [SUBDRV-1:0] flush_pend;

    logic [TRK_W-1:0]  init_trk;
    logic [SUBDRV-1:0] has_work;
    logic [SUBDRV-1:0] w_wr;
    logic [TRK_W-1:0]  w_trk [SUBDRV];
    logic              found;
    logic [SW-1:0]     pick;

    assign init_trk = drv_type ? TRK_W'(INIT_TRK1) : TRK_W'(INIT_TRK0);

    function automatic logic trk_valid(input logic [TRK_W-1:0] t);
        return (t != '0) && (t != '1);
    endfunction

    // Per-sub-drive work decision; a dirty buffer is always written back
    // before any read replaces it.
    always_comb begin
        for (int n = 0; n < SUBDRV; n++) begin
            logic any;
            any      = 1'b1;
            w_wr[n]  = 1'b0;
            w_trk[n] = ltrack[n];
            if (flush_pend[n]) begin
                w_wr[n] = 1'b1;
            end else if (init[n]) begin
                w_wr[n]  = dirty[n];
                w_trk[n] = dirty[n] ? ltrack[n] : init_trk;
            end else if (trk_valid(track[n]) && track[n] != ltrack[n]) begin
                w_wr[n]  = dirty[n];
                w_trk[n] = dirty[n] ? ltrack[n] : track[n];
            end else begin
                any = 1'b0;
            end
            has_work[n] = mounted[n] && any && trk_valid(w_trk[n]);
        end
    end

    // drv_sel first, then round-robin upward from drv_act+1.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        if (int'(drv_sel) < SUBDRV && has_work[drv_sel]) begin
            found = 1'b1;
            pick  = drv_sel;
        end
        for (int k = 1; k <= SUBDRV; k++) begin
            int idx;
            idx = (int'(drv_act) + k) % SUBDRV;
            if (!found && has_work[idx]) begin
                found = 1'b1;
                pick  = SW'(idx);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            is_wr      <= 1'b0;
            discard    <= 1'b0;
            tgt        <= '0;
            geom_trk   <= '0;
            drv_act    <= '0;
            mounted_q  <= '0;
            init       <= '0;
            flush_pend <= '0;
            dirty      <= '0;
            busy       <= '0;
            sd_rd      <= '0;
            sd_wr      <= '0;
            for (int n = 0; n < SUBDRV; n++) begin
                sd_lba[n]     <= '0;
                sd_blk_cnt[n] <= '0;
                ltrack[n]     <= '1;
            end
        end else begin
            // mounted_q starts at 0, so drives mounted across reset see a
            // rising edge on the first cycle and get their init flag.
            mounted_q <= mounted;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        drv_act    <= pick;
                        busy[pick] <= 1'b1;
                        geom_trk   <= w_trk[pick];
                        tgt        <= w_trk[pick];
                        is_wr      <= w_wr[pick];
                        discard    <= 1'b0;
                        state      <= S_LOOKUP;
                    end
                end
                S_LOOKUP: state <= S_LATCH;
                S_LATCH: begin
                    sd_lba[drv_act]     <= geom_lba;
                    sd_blk_cnt[drv_act] <= geom_cnt;
                    if (is_wr) begin
                        dirty[drv_act]      <= 1'b0;
                        flush_pend[drv_act] <= 1'b0;
                        sd_wr[drv_act]      <= 1'b1;
                    end else begin
                        sd_rd[drv_act]      <= 1'b1;
                    end
                    state <= S_REQ;
                end
                S_REQ: begin
                    if (sd_ack[drv_act]) begin
                        sd_rd[drv_act] <= 1'b0;
                        sd_wr[drv_act] <= 1'b0;
                        state          <= S_XFER;
                    end
                end
                S_XFER: begin
                    // ack was high on entry, so low here is its falling edge
                    if (!sd_ack[drv_act]) begin
                        if (!is_wr && !discard) begin
                            ltrack[drv_act] <= tgt;
                            init[drv_act]   <= 1'b0;
                        end
                        busy[drv_act] <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Set events come after the FSM clears so they win a tie.
            for (int n = 0; n < SUBDRV; n++) begin
                if (flush[n] && dirty[n])
                    flush_pend[n] <= 1'b1;
                if (wr_mark[n] && mounted[n])
                    dirty[n] <= 1'b1;
                if (mounted[n] && !mounted_q[n])
                    init[n] <= 1'b1;
                if (!mounted[n] && mounted_q[n]) begin
                    dirty[n]      <= 1'b0;
                    flush_pend[n] <= 1'b0;
                    init[n]       <= 1'b0;
                    ltrack[n]     <= '1;
                    if (state != S_IDLE && drv_act == SW'(n))
                        discard <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ieeedrv_track_ctl.sv
// tb/tb_ieeedrv_track_ctl.sv - directed self-checking bench for ieeedrv_track_ctl

module tb_ieeedrv_track_ctl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        drv_type;
    logic [1:0]  mounted;
    logic [0:0]  drv_sel;
    logic [7:0]  track [2];
    logic [1:0]  wr_mark;
    logic [1:0]  flush;
    logic [7:0]  geom_trk;
    logic [31:0] geom_lba;
    logic [5:0]  geom_cnt;
    logic [31:0] sd_lba [2];
    logic [5:0]  sd_blk_cnt [2];
    logic [1:0]  sd_rd;
    logic [1:0]  sd_wr;
    logic [1:0]  sd_ack;
    logic [0:0]  drv_act;
    logic [7:0]  ltrack [2];
    logic [1:0]  dirty;
    logic [1:0]  busy;

    int total = 0;
    int bad   = 0;

    ieeedrv_track_ctl dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .drv_type   (drv_type),
        .mounted    (mounted),
        .drv_sel    (drv_sel),
        .track      (track),
        .wr_mark    (wr_mark),
        .flush      (flush),
        .geom_trk   (geom_trk),
        .geom_lba   (geom_lba),
        .geom_cnt   (geom_cnt),
        .sd_lba     (sd_lba),
        .sd_blk_cnt (sd_blk_cnt),
        .sd_rd      (sd_rd),
        .sd_wr      (sd_wr),
        .sd_ack     (sd_ack),
        .drv_act    (drv_act),
        .ltrack     (ltrack),
        .dirty      (dirty),
        .busy       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Geometry table: lba = trk*28+11, cnt = 26 for even tracks, 25 for odd.
    // Track 39 -> 1103/25, 40 -> 1131/26, 41 -> 1159/25.
    always @(posedge clk_sys) begin
        geom_lba <= 32'(geom_trk) * 32'd28 + 32'd11;
        geom_cnt <= geom_trk[0] ? 6'd25 : 6'd26;
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Waits for a request on sub-drive n, checks it, then plays the SD side.
    task automatic serve(input int n, input bit exp_wr, input logic [31:0] lba,
                         input logic [5:0] cnt, input bit wm_xfer, input bit unmount_xfer,
                         input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (sd_rd[n] || sd_wr[n]) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_req_seen"}, 64'(seen), 64'd1);
        if (!seen) return;
        chk({tag, "_wr"},     64'(sd_wr[n]), 64'(exp_wr));
        chk({tag, "_lba"},    64'(sd_lba[n]), 64'(lba));
        chk({tag, "_cnt"},    64'(sd_blk_cnt[n]), 64'(cnt));
        chk({tag, "_act"},    64'(drv_act), 64'(n));
        chk({tag, "_busy"},   64'(busy[n]), 64'd1);
        if (exp_wr) chk({tag, "_dirty_clr"}, 64'(dirty[n]), 64'd0);
        sd_ack[n] = 1'b1;
        tick();
        chk({tag, "_req_drop"}, 64'(sd_rd[n] | sd_wr[n]), 64'd0);
        if (wm_xfer) wr_mark[n] = 1'b1;
        if (unmount_xfer) mounted[n] = 1'b0;
        tick();
        wr_mark[n] = 1'b0;
        tick();
        chk({tag, "_busy_hold"}, 64'(busy[n]), 64'd1);
        sd_ack[n] = 1'b0;
        tick();
        chk({tag, "_busy_done"}, 64'(busy[n]), 64'd0);
    endtask

    task automatic no_req(input int n, input int cycles, input string tag);
        bit seen = 1'b0;
        repeat (cycles) begin
            tick();
            seen |= sd_rd[n] | sd_wr[n] | busy[n];
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        bit hit;
        reset_n  = 1'b0;
        drv_type = 1'b0;
        mounted  = 2'b01;
        drv_sel  = 1'b0;
        track[0] = 8'd0;
        track[1] = 8'd0;
        wr_mark  = '0;
        flush    = '0;
        sd_ack   = '0;
        tick();
        tick();
        chk("rst_ltrack0", 64'(ltrack[0]), 64'hFF);
        chk("rst_ltrack1", 64'(ltrack[1]), 64'hFF);
        chk("rst_busy",    64'(busy), 64'd0);
        chk("rst_rdwr",    64'({sd_rd, sd_wr}), 64'd0);
        chk("rst_act",     64'(drv_act), 64'd0);
        chk("rst_lba0",    64'(sd_lba[0]), 64'd0);
        reset_n = 1'b1;

        // Mount init read of directory track 39
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (geom_trk == 8'd39) begin
                hit = 1'b1;
                break;
            end
        end
        chk("init_geom_trk", 64'(hit), 64'd1);
        chk("init_busy_t1", 64'(busy[0]), 64'd1);
        tick();
        chk("init_rd_t2", 64'(sd_rd[0]), 64'd0);
        tick();
        chk("init_rd_t3", 64'(sd_rd[0]), 64'd1);
        serve(0, 1'b0, 32'd1103, 6'd25, 1'b0, 1'b0, "init");
        chk("init_ltrack0", 64'(ltrack[0]), 64'd39);
        no_req(1, 8, "init_sub1_quiet");

        // Clean step to track 40
        track[0] = 8'd40;
        serve(0, 1'b0, 32'd1131, 6'd26, 1'b0, 1'b0, "step40");
        chk("step40_ltrack", 64'(ltrack[0]), 64'd40);

        // Dirty step to 41: write 40 then read 41
        wr_mark[0] = 1'b1;
        tick();
        wr_mark[0] = 1'b0;
        chk("wm_dirty", 64'(dirty[0]), 64'd1);
        track[0] = 8'd41;
        serve(0, 1'b1, 32'd1131, 6'd26, 1'b0, 1'b0, "wb40");
        chk("wb40_ltrack", 64'(ltrack[0]), 64'd40);
        serve(0, 1'b0, 32'd1159, 6'd25, 1'b0, 1'b0, "rd41");
        chk("rd41_ltrack", 64'(ltrack[0]), 64'd41);
        chk("rd41_dirty", 64'(dirty[0]), 64'd0);

        // Flush write-back with wr_mark during XFER keeps dirty set
        wr_mark[0] = 1'b1;
        tick();
        wr_mark[0] = 1'b0;
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        serve(0, 1'b1, 32'd1159, 6'd25, 1'b1, 1'b0, "fl41");
        chk("fl41_dirty_kept", 64'(dirty[0]), 64'd1);
        no_req(0, 6, "fl41_quiet");
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        serve(0, 1'b1, 32'd1159, 6'd25, 1'b0, 1'b0, "fl41b");
        chk("fl41b_dirty", 64'(dirty[0]), 64'd0);
        chk("fl41b_ltrack", 64'(ltrack[0]), 64'd41);

        // Both need reads, drv_sel=1 served first
        mounted = 2'b11;
        drv_sel = 1'b1;
        tick();
        track[0] = 8'd40;
        serve(1, 1'b0, 32'd1103, 6'd25, 1'b0, 1'b0, "prio1");
        chk("prio1_ltrack", 64'(ltrack[1]), 64'd39);
        serve(0, 1'b0, 32'd1131, 6'd26, 1'b0, 1'b0, "prio0");
        chk("prio0_ltrack", 64'(ltrack[0]), 64'd40);

        // Unmount sub-drive 1 during a read XFER
        wr_mark[1] = 1'b1;
        tick();
        wr_mark[1] = 1'b0;
        chk("sub1_dirty", 64'(dirty[1]), 64'd1);
        track[1] = 8'd40;
        serve(1, 1'b1, 32'd1103, 6'd25, 1'b0, 1'b0, "wb39s1");
        serve(1, 1'b0, 32'd1131, 6'd26, 1'b0, 1'b1, "um_rd");
        chk("um_ltrack", 64'(ltrack[1]), 64'hFF);
        chk("um_dirty", 64'(dirty[1]), 64'd0);
        no_req(1, 8, "um_quiet");

        // Asynchronous reset during an active request
        track[0] = 8'd41;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sd_rd[0]) begin
                hit = 1'b1;
                break;
            end
        end
        chk("ar_req_seen", 64'(hit), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_rd_drop", 64'(sd_rd[0]), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_ltrack0", 64'(ltrack[0]), 64'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
